// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared types and defaults for the clock divider bank
// Holds the lock/settle FSM state encoding and the default sizing of the bank.
package clk_pkg;

    localparam int NCH_DEFAULT    = 4;
    localparam int CW_DEFAULT     = 16;
    localparam int SETTLE_DEFAULT = 1024;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one programmable divider channel with shadowed config
// Ports: clkin/reset; run_next (bank is in RUN next cycle); en (channel enable);
// load/div_in/duty_in (shadow capture); clkoutd/tick (registered outputs);
// pending (shadow not yet applied).
module clk_div_ch
    import clk_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clkin,
    input  logic          reset,
    input  logic          run_next,
    input  logic          en,
    input  logic          load,
    input  logic [CW-1:0] div_in,
    input  logic [CW-1:0] duty_in,
    output logic          clkoutd,
    output logic          tick,
    output logic          pending
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] duty_q, duty_d;
    logic [CW-1:0] sdiv_q, sdiv_d;
    logic [CW-1:0] sduty_q, sduty_d;
    logic          pend_q, pend_d;
    logic          live_q, live_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;

    logic [CW-1:0] last_cnt;
    logic          go;
    logic          wrap;
    logic          apply;

    always_comb begin
        // A divide value of 0 behaves as 1, so the last count is 0 in both cases.
        last_cnt = (div_q == '0) ? '0 : div_q - CW'(1);
        go       = run_next & en;
        wrap     = (cnt_q >= last_cnt);
        // live_q says the channel produced valid output this cycle; anything
        // not live (disabled, outside RUN, just starting) takes the shadow now.
        apply    = pend_q & (~go | ~live_q | wrap);

        sdiv_d  = sdiv_q;
        sduty_d = sduty_q;
        pend_d  = pend_q;
        div_d   = div_q;
        duty_d  = duty_q;
        // A fresh load beats an apply in the same cycle; the new values then
        // wait for the following wrap.
        if (load) begin
            sdiv_d  = div_in;
            sduty_d = duty_in;
            pend_d  = 1'b1;
        end else if (apply) begin
            div_d  = sdiv_q;
            duty_d = sduty_q;
            pend_d = 1'b0;
        end

        live_d = go;
        if (!go || !live_q || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Outputs are registered from the next counter value so they line up
        // with cnt_q in the cycle they are visible.
        tick_d = go & (cnt_d == '0);
        clk_d  = go & (cnt_d < duty_d);
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            div_q   <= CW'(1);
            duty_q  <= '0;
            sdiv_q  <= CW'(1);
            sduty_q <= '0;
            pend_q  <= 1'b0;
            live_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            duty_q  <= duty_d;
            sdiv_q  <= sdiv_d;
            sduty_q <= sduty_d;
            pend_q  <= pend_d;
            live_q  <= live_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign clkoutd = clk_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - lock-qualified bank of phase-aligned clock dividers
// Ports: clkin/reset; lock (async PLL lock); ch_en, div_val, duty_val, cfg_load
// (per-channel config, CW bits per channel); clkoutd/tick (per-channel outputs);
// ready (bank running); cfg_ack (last load fully applied).
module clk_div_bank
    import clk_pkg::*;
#(
    parameter int NCH    = NCH_DEFAULT,
    parameter int CW     = CW_DEFAULT,
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              lock,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH*CW-1:0] div_val,
    input  logic [NCH*CW-1:0] duty_val,
    input  logic              cfg_load,
    output logic [NCH-1:0]    clkoutd,
    output logic [NCH-1:0]    tick,
    output logic              ready,
    output logic              cfg_ack
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    logic          sync1_q;
    logic          lock_s_q;
    fsm_state_t    state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          ready_q, ready_d;
    logic          ack_wait_q, ack_wait_d;
    logic          cfg_ack_q, cfg_ack_d;
    logic [NCH-1:0] pend;

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                scnt_d = '0;
                if (lock_s_q) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    scnt_d  = '0;
                end else if (scnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                    scnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s_q) state_d = ST_WAIT_LOCK;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                scnt_d  = '0;
            end
        endcase
        ready_d = (state_d == ST_RUN);

        // Only the newest load is acknowledged: a load restarts the wait, and
        // the ack fires once every channel has dropped its pending flag.
        ack_wait_d = ack_wait_q;
        cfg_ack_d  = 1'b0;
        if (cfg_load) begin
            ack_wait_d = 1'b1;
        end else if (ack_wait_q && (pend == '0)) begin
            ack_wait_d = 1'b0;
            cfg_ack_d  = 1'b1;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            lock_s_q   <= 1'b0;
            state_q    <= ST_WAIT_LOCK;
            scnt_q     <= '0;
            ready_q    <= 1'b0;
            ack_wait_q <= 1'b0;
            cfg_ack_q  <= 1'b0;
        end else begin
            sync1_q    <= lock;
            lock_s_q   <= sync1_q;
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            ready_q    <= ready_d;
            ack_wait_q <= ack_wait_d;
            cfg_ack_q  <= cfg_ack_d;
        end
    end

    // Channels see the next-cycle RUN state so their registered outputs turn
    // on and off in the same cycle as ready.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clk_div_ch #(
            .CW (CW)
        ) u_ch (
            .clkin    (clkin),
            .reset    (reset),
            .run_next (ready_d),
            .en       (ch_en[i]),
            .load     (cfg_load),
            .div_in   (div_val[i*CW +: CW]),
            .duty_in  (duty_val[i*CW +: CW]),
            .clkoutd  (clkoutd[i]),
            .tick     (tick[i]),
            .pending  (pend[i])
        );
    end

    assign ready   = ready_q;
    assign cfg_ack = cfg_ack_q;

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NCH, default 4: number of divider channels (1..8).
REQ-002 SHALL have parameter CW, default 16: width of each divide/duty value.
REQ-003 SHALL have parameter SETTLE, default 1024: clkin cycles from synchronised lock until ready.
REQ-004 SHALL have port clkin  input  1: single clock, the PLL output domain.
REQ-005 SHALL have port reset  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port lock  input  1: PLL lock, asynchronous to clkin.
REQ-007 SHALL have port ch_en  input  NCH: per-channel enable.
REQ-008 SHALL have port div_val  input  NCH*CW: period in cycles per channel, channel i at bits [i*CW +: CW].
REQ-009 SHALL have port duty_val  input  NCH*CW: high-cycle count per channel, same packing.
REQ-010 SHALL have port cfg_load  input  1: one-cycle strobe that captures div_val/duty_val.
REQ-011 SHALL have port clkoutd  output  NCH: registered divided square outputs.
REQ-012 SHALL have port tick  output  NCH: one-cycle pulse at each channel period start.
REQ-013 SHALL have port ready  output  1: lock qualified, channels running.
REQ-014 SHALL have port cfg_ack  output  1: one-cycle pulse when all channels have applied the last load.

Function
REQ-015 SHALL pass lock through a 2-flop synchroniser (lock_s) before any use.
REQ-016 SHALL implement FSM WAIT_LOCK -> SETTLE on lock_s=1 -> RUN after exactly SETTLE cycles in SETTLE.
REQ-017 SHALL return to WAIT_LOCK from SETTLE or RUN on the cycle after lock_s=0, clearing the settle counter.
REQ-018 SHALL drive ready=1 only in RUN; clkoutd and tick SHALL be 0 outside RUN.
REQ-019 SHALL zero every channel counter on RUN entry so all enabled channels are phase-aligned; the first tick occurs on the first RUN cycle.
REQ-020 SHALL count each enabled channel 0..D-1 and wrap, where D = active div; D=0 SHALL be treated as 1.
REQ-021 SHALL assert tick[i] on the cycle counter[i]=0.
REQ-022 SHALL drive clkoutd[i]=1 while counter[i] < active duty; duty=0 gives constant 0; duty>=D gives constant 1.
REQ-023 SHALL, for D=1, assert tick[i] every cycle.
REQ-024 SHALL hold a disabled channel's counter at 0 with clkoutd=0 and tick=0; on re-enable, counting SHALL start at 0 with tick the next cycle.
REQ-025 SHALL copy all inputs into shadow registers on cfg_load and mark every channel pending.
REQ-026 SHALL apply the shadow to an enabled running channel in the cycle its counter wraps to 0, and to a disabled channel or any channel outside RUN immediately.
REQ-027 SHALL pulse cfg_ack for one cycle the cycle after the last pending flag clears.
REQ-028 SHALL, on cfg_load while pending, overwrite the shadow, re-mark all channels pending, and issue a single cfg_ack for the newest load only.
REQ-029 SHALL give cfg_load priority over the apply of the same cycle, so the channel applies the new values at its next wrap.

Reset
REQ-030 SHALL, on reset, asynchronously force FSM=WAIT_LOCK, synchroniser, counters and pending flags to 0, active and shadow div=1 and duty=0, and all outputs to 0.
REQ-031 SHALL treat reset mid-operation identically, with no cfg_ack issued for a load interrupted by reset.

Structure
REQ-032 SHALL place the FSM state enumeration and the default values of NCH, CW and SETTLE in shared package clk_pkg.
REQ-033 SHALL implement one channel as sub-module clk_div_ch, instantiated NCH times; the FSM, synchroniser and ack logic stay in the top level.

Verification
REQ-034 SETTLE=16, lock rises -> ready rises at edge 2+16+1 (±0) after first sampling of lock; no tick before then.
REQ-035 ch0 div=4 duty=2 -> clkoutd[0] pattern 1100 repeating, tick[0] every 4th cycle, aligned with ch1 div=8.
REQ-036 Running div=4; load div=6 at counter=1 -> two more cycles at period 4, then period 6; cfg_ack one cycle after the switch.
REQ-037 div=0, duty=0 and div=3 duty=5 -> tick every cycle with clkoutd=0; period 3 with constant clkoutd=1.
REQ-038 lock drops in RUN -> ready=0 and outputs=0 three cycles later; lock restored -> re-settle and aligned restart.
REQ-039 Two cfg_loads 2 cycles apart, then reset mid-pending -> only one cfg_ack (no reset) / none (reset), and div=1 after reset.
